// File: rtl/corrode_map_wr_ctrl_pkg.sv
// corrode_map_wr_ctrl_pkg: shared map geometry, state encoding and state type for the corrosion-map write controller.
// Geometry defines (override on the command line): CORROSION_DX, CORROSION_DY, CORRODE_MAP_CELLS.
// Optional feature macro used by the controller: CORRODE_PINGPONG_EN.
`ifndef CORROSION_DX
`define CORROSION_DX 8
`endif
`ifndef CORROSION_DY
`define CORROSION_DY 4
`endif
`ifndef CORRODE_MAP_CELLS
`define CORRODE_MAP_CELLS (`CORROSION_DX * `CORROSION_DY)
`endif

package corrode_map_wr_ctrl_pkg;
   localparam int   MAP_DX    = `CORROSION_DX;
   localparam int   MAP_DY    = `CORROSION_DY;
   localparam int   MAP_CELLS = `CORRODE_MAP_CELLS;
   localparam int   MAP_AW    = 11;
   localparam logic MAP_CLR   = 1'b1;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      CLEAR = ST_CLEAR,
      RUN   = ST_RUN,
      DONE  = ST_DONE
   } state_t;
endpackage

// File: rtl/corrode_map_wr_ctrl.sv
// corrode_map_wr_ctrl: write-side sequencer for the 2048x1 corrosion-map RAM port A (detector cells vs. clear sweep).
// Ports: sys_clk_1/sys_rst_n_1 (async active-low); i_frame_start, i_cell_valid, i_cell_wb, i_clr_req in;
//        o_cell_ready, o_we, o_ada[A_W-1:0], o_din, o_frame_done, o_bank_tgl, o_overflow, o_busy out (all registered).
// Macro CORRODE_PINGPONG_EN: when defined, the write bank alternates per published map; otherwise bank 0 only.
module corrode_map_wr_ctrl
   import corrode_map_wr_ctrl_pkg::*;
#(
   parameter int   C_L     = MAP_DX,
   parameter int   C_H     = MAP_DY,
   parameter int   A_W     = MAP_AW,
   parameter logic CLR_VAL = MAP_CLR
) (
   input  logic           sys_clk_1,
   input  logic           sys_rst_n_1,
   input  logic           i_frame_start,
   input  logic           i_cell_valid,
   input  logic           i_cell_wb,
   output logic           o_cell_ready,
   input  logic           i_clr_req,
   output logic           o_we,
   output logic [A_W-1:0] o_ada,
   output logic           o_din,
   output logic           o_frame_done,
   output logic           o_bank_tgl,
   output logic           o_overflow,
   output logic           o_busy
);
   localparam int CELLS = C_L * C_H;
   localparam int CW    = A_W - 1;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           pend_q, pend_d;
   logic           bank_q, bank_d;
   logic           we_q, we_d;
   logic [A_W-1:0] ada_q, ada_d;
   logic           din_q, din_d;
   logic           done_q, done_d;
   logic           tgl_q, tgl_d;
   logic           ovf_q, ovf_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           last;

   assign last = (cnt_q == CW'(CELLS - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      bank_d  = bank_q;
      we_d    = 1'b0;
      ada_d   = ada_q;
      din_d   = din_q;
      done_d  = 1'b0;
      tgl_d   = tgl_q;
      // cells with no frame in progress are lost and flagged
      ovf_d   = ovf_q | (i_cell_valid & (state_q == IDLE || state_q == DONE));
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) begin
               done_d = 1'b1;
               tgl_d  = ~tgl_q;
`ifdef CORRODE_PINGPONG_EN
               bank_d = ~bank_q;
`endif
            end
            // a simultaneous frame start is remembered and resumed after the sweep
            if (i_clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
               pend_d  = i_frame_start;
            end else if (i_frame_start) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            we_d   = 1'b1;
            ada_d  = {bank_q, cnt_q};
            din_d  = CLR_VAL;
            cnt_d  = cnt_q + 1'b1;
            pend_d = pend_q | i_frame_start;
            if (last) begin
               state_d = (pend_q | i_frame_start) ? RUN : IDLE;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         end
         RUN: begin
            // a new frame start abandons the partial map; a coincident cell is discarded with it
            if (i_frame_start) begin
               cnt_d = '0;
            end else if (i_cell_valid) begin
               we_d  = 1'b1;
               ada_d = {bank_q, cnt_q};
               din_d = i_cell_wb;
               cnt_d = cnt_q + 1'b1;
               if (last) state_d = DONE;
            end
         end
      endcase
`ifndef CORRODE_PINGPONG_EN
      bank_d  = 1'b0;
`endif
      ready_d = (state_d == IDLE) || (state_d == RUN);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk_1 or negedge sys_rst_n_1) begin
      if (!sys_rst_n_1) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         bank_q  <= 1'b0;
         we_q    <= 1'b0;
         ada_q   <= '0;
         din_q   <= 1'b0;
         done_q  <= 1'b0;
         tgl_q   <= 1'b0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         bank_q  <= bank_d;
         we_q    <= we_d;
         ada_q   <= ada_d;
         din_q   <= din_d;
         done_q  <= done_d;
         tgl_q   <= tgl_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign o_cell_ready = ready_q;
   assign o_we         = we_q;
   assign o_ada        = ada_q;
   assign o_din        = din_q;
   assign o_frame_done = done_q;
   assign o_bank_tgl   = tgl_q;
   assign o_overflow   = ovf_q;
   assign o_busy       = busy_q;
endmodule

// File: tb/tb_corrode_map_wr_ctrl.sv
// tb_corrode_map_wr_ctrl: scoreboard bench for corrode_map_wr_ctrl; expected RAM writes are queued as stimulus is driven
// and popped by a write monitor. Honours CORRODE_PINGPONG_EN for the expected bank sequence.
module tb_corrode_map_wr_ctrl;
   import corrode_map_wr_ctrl_pkg::*;
   localparam int AW = MAP_AW;
   localparam int N  = MAP_CELLS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_frame_start = 1'b0;
   logic          i_cell_valid = 1'b0;
   logic          i_cell_wb = 1'b0;
   logic          i_clr_req = 1'b0;
   logic          o_cell_ready, o_we, o_din, o_frame_done, o_bank_tgl, o_overflow, o_busy;
   logic [AW-1:0] o_ada;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [AW:0] exp_q[$];
   logic exp_bank = 1'b0;
   logic exp_tgl = 1'b0;

   corrode_map_wr_ctrl dut (
      .sys_clk_1(clk), .sys_rst_n_1(rst_n), .i_frame_start(i_frame_start), .i_cell_valid(i_cell_valid),
      .i_cell_wb(i_cell_wb), .o_cell_ready(o_cell_ready), .i_clr_req(i_clr_req), .o_we(o_we), .o_ada(o_ada),
      .o_din(o_din), .o_frame_done(o_frame_done), .o_bank_tgl(o_bank_tgl), .o_overflow(o_overflow), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_frame_done) done_cnt++;
         if (o_we) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got ada=%h din=%b, no write expected", o_ada, o_din);
            end else begin
               logic [AW:0] e;
               e = exp_q.pop_front();
               if ({o_ada, o_din} !== e) begin
                  errors++;
                  $display("FAIL write: got ada=%h din=%b, expected ada=%h din=%b", o_ada, o_din, e[AW:1], e[0]);
               end
            end
         end
      end
   end

   function automatic logic [AW:0] wr(input logic bank, input int idx, input logic d);
      logic [AW-2:0] c;
      c = (AW-1)'(idx);
      return {bank, c, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
   endtask

   task automatic send_cells(input int first, input int n, input int gap_max);
      for (int i = first; i < first + n; i++) begin
         i_cell_wb = ~i[0];
         exp_q.push_back(wr(exp_bank, i, ~i[0]));
         i_cell_valid = 1'b1;
         tick();
         i_cell_valid = 1'b0;
         repeat ($urandom_range(gap_max, 0)) tick();
      end
   endtask

   task automatic frame_published();
      exp_tgl = ~exp_tgl;
`ifdef CORRODE_PINGPONG_EN
      exp_bank = ~exp_bank;
`endif
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({o_cell_ready, o_we, o_ada, o_din, o_frame_done, o_bank_tgl, o_overflow, o_busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b we=%b ada=%h din=%b done=%b tgl=%b ovf=%b busy=%b, expected all 0",
                  o_cell_ready, o_we, o_ada, o_din, o_frame_done, o_bank_tgl, o_overflow, o_busy);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({o_cell_ready, o_busy, o_overflow} !== 3'b100) begin
         errors++;
         $display("FAIL idle_after_reset: got ready=%b busy=%b ovf=%b, expected 1 0 0", o_cell_ready, o_busy, o_overflow);
      end
   endtask

   task automatic test_full_frame();
      int d0;
      d0 = done_cnt;
      pulse_start();
      checks++;
      if ({o_cell_ready, o_busy} !== 2'b11) begin
         errors++;
         $display("FAIL run_entry: got ready=%b busy=%b, expected 1 1", o_cell_ready, o_busy);
      end
      send_cells(0, N, 2);
      repeat (3) tick();
      frame_published();
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL frame_done_count: got %0d, expected 1", done_cnt - d0);
      end
      checks++;
      if (o_bank_tgl !== exp_tgl || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_publish: got tgl=%b busy=%b, expected tgl=%b busy=0", o_bank_tgl, o_busy, exp_tgl);
      end
   endtask

   task automatic count_clear(output int lows);
      lows = 0;
      for (int k = 0; k < 3 * N; k++) begin
         @(negedge clk);
         i_cell_valid = (k < 4);
         if (o_cell_ready) break;
         lows++;
      end
      i_cell_valid = 1'b0;
   endtask

   task automatic test_clear();
      int lows;
      for (int i = 0; i < N; i++) exp_q.push_back(wr(exp_bank, i, 1'b1));
      i_clr_req = 1'b1;
      tick();
      i_clr_req = 1'b0;
      count_clear(lows);
      checks++;
      if (lows !== N) begin
         errors++;
         $display("FAIL clear_ready_low: got %0d cycles, expected %0d", lows, N);
      end
      repeat (2) tick();
      checks++;
      if (o_busy !== 1'b0 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL clear_end: got busy=%b pending_writes=%0d, expected busy=0 pending_writes=0", o_busy, exp_q.size());
      end
   endtask

   task automatic test_clr_and_start();
      int lows, d0;
      d0 = done_cnt;
      for (int i = 0; i < N; i++) exp_q.push_back(wr(exp_bank, i, 1'b1));
      i_clr_req = 1'b1;
      i_frame_start = 1'b1;
      tick();
      i_clr_req = 1'b0;
      i_frame_start = 1'b0;
      count_clear(lows);
      checks++;
      if (lows !== N || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL clr_then_run: got low=%0d busy=%b, expected low=%0d busy=1", lows, o_busy, N);
      end
      send_cells(0, N, 0);
      repeat (3) tick();
      frame_published();
      checks++;
      if (done_cnt - d0 !== 1 || o_bank_tgl !== exp_tgl) begin
         errors++;
         $display("FAIL clr_then_run_publish: got done=%0d tgl=%b, expected done=1 tgl=%b", done_cnt - d0, o_bank_tgl, exp_tgl);
      end
   endtask

   task automatic test_abandon();
      int d0;
      d0 = done_cnt;
      pulse_start();
      send_cells(0, 5, 1);
      pulse_start();
      repeat (3) tick();
      checks++;
      if (done_cnt !== d0 || o_bank_tgl !== exp_tgl || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL abandon: got done=%0d tgl=%b busy=%b, expected done=0 tgl=%b busy=1", done_cnt - d0, o_bank_tgl, o_busy, exp_tgl);
      end
      send_cells(0, N, 1);
      repeat (3) tick();
      frame_published();
      checks++;
      if (done_cnt - d0 !== 1 || o_bank_tgl !== exp_tgl) begin
         errors++;
         $display("FAIL abandon_publish: got done=%0d tgl=%b, expected done=1 tgl=%b", done_cnt - d0, o_bank_tgl, exp_tgl);
      end
   endtask

   task automatic test_overflow();
      checks++;
      if (o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_pre: got %b, expected 0", o_overflow);
      end
      i_cell_wb = 1'b0;
      i_cell_valid = 1'b1;
      tick();
      i_cell_valid = 1'b0;
      repeat (2) tick();
      checks++;
      if (o_overflow !== 1'b1 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL overflow_set: got ovf=%b pending_writes=%0d, expected ovf=1 pending_writes=0", o_overflow, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      logic t0;
      d0 = done_cnt;
      t0 = o_bank_tgl;
      for (int f = 0; f < 2; f++) begin
         pulse_start();
         send_cells(0, N, 0);
         tick();
         frame_published();
      end
      repeat (3) tick();
      checks++;
      if (done_cnt - d0 !== 2 || o_bank_tgl !== t0 || o_bank_tgl !== exp_tgl) begin
         errors++;
         $display("FAIL back_to_back: got done=%0d tgl=%b, expected done=2 tgl=%b", done_cnt - d0, o_bank_tgl, exp_tgl);
      end
      checks++;
      if (o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: got %b, expected 1", o_overflow);
      end
   endtask

   task automatic test_reset_mid_frame();
      pulse_start();
      send_cells(0, 3, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({o_cell_ready, o_we, o_frame_done, o_bank_tgl, o_overflow, o_busy} !== '0 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL async_reset: got ready=%b we=%b done=%b tgl=%b ovf=%b busy=%b pending=%0d, expected all 0",
                  o_cell_ready, o_we, o_frame_done, o_bank_tgl, o_overflow, o_busy, exp_q.size());
      end
      exp_bank = 1'b0;
      exp_tgl = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      pulse_start();
      send_cells(0, N, 0);
      repeat (3) tick();
      frame_published();
      checks++;
      if (o_bank_tgl !== exp_tgl || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_frame: got tgl=%b ovf=%b, expected tgl=%b ovf=0", o_bank_tgl, o_overflow, exp_tgl);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_clear();
      test_clr_and_start();
      test_abandon();
      test_overflow();
      test_back_to_back();
      test_reset_mid_frame();
      repeat (2) tick();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL missing_writes: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/corrode_map_wr_ctrl.md
Name: corrode_map_wr_ctrl

Overview:
- Write-side sequencer for the 1-bit corrosion-map RAM (2048 x 1, port A) in the sys_clk_1 domain.
- Arbitrates the port between the corrosion detector's cell stream and a map-clear sweep.
- Generates write enable, address and data per frame, then publishes the completed map to the sys_clk_2 display side through a toggle flag.

Parameters:
- C_L, `CORROSION_DX, cells per map row.
- C_H, `CORROSION_DY, cell rows per map; C_L*C_H <= 1024.
- A_W, 11, RAM address width.
- CLR_VAL, 1'b1, value written by a clear sweep (1 = no corrosion).

Ports:
- sys_clk_1  in  1  write-domain clock.
- sys_rst_n_1  in  1  reset, asynchronous, active-low.
- i_frame_start  in  1  one-cycle pulse, start of a detector frame.
- i_cell_valid  in  1  detector cell result valid.
- i_cell_wb  in  1  detector cell result (0 = corroded).
- o_cell_ready  out  1  controller accepts cells.
- i_clr_req  in  1  one-cycle pulse, request a full clear of the write bank.
- o_we  out  1  RAM port-A cea.
- o_ada  out  A_W  RAM port-A address.
- o_din  out  1  RAM port-A data.
- o_frame_done  out  1  one-cycle pulse, map fully written.
- o_bank_tgl  out  1  level toggles on each published map (for CDC).
- o_overflow  out  1  sticky, cells received beyond C_L*C_H.
- o_busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered. Every output resets to 0 under sys_rst_n_1.
- Internal state resets: wr_bank=0, cell_cnt=0, state=IDLE.
- Addressing: o_ada = {wr_bank, cell_cnt[A_W-2:0]}, where cell_cnt runs 0..C_L*C_H-1.
- States:
  - IDLE: o_cell_ready=1. i_clr_req goes to CLEAR. i_frame_start clears cell_cnt and goes to RUN. If both arrive in the same cycle, CLEAR wins and the frame start is latched as pending.
  - CLEAR: o_cell_ready=0. Writes CLR_VAL to addresses wr_bank:0..C_L*C_H-1, one per cycle, so the sweep takes C_L*C_H cycles. Cells arriving during CLEAR are dropped. At the end, go to RUN if a frame start is pending, else IDLE. A frame start arriving mid-sweep sets pending.
  - RUN: o_cell_ready=1. Each i_cell_valid produces, one cycle later, o_we=1, o_din=i_cell_wb, o_ada at the current cell_cnt; cell_cnt then increments. When the write with cell_cnt = C_L*C_H-1 is issued, go to DONE.
  - DONE: lasts 1 cycle. Pulses o_frame_done, toggles o_bank_tgl, flips wr_bank (ping-pong only), returns to IDLE.
- Cells in IDLE or DONE without an active frame: dropped, and o_overflow is set. o_overflow clears only on reset.
- i_frame_start during RUN: the partial frame is abandoned (no publish, no bank flip), cell_cnt restarts at 0, RUN continues.
- i_clr_req during RUN: ignored.
- o_we is never high in two states at once. Exactly one writer per cycle.
- Reset mid-operation: immediate return to IDLE. The RAM is not cleared; the display side keeps its last bank.

Optional Feature:
- Macro: CORRODE_PINGPONG_EN.
- Defined: wr_bank alternates per published map, so the display reads bank ~wr_bank, delivered via synchronized o_bank_tgl.
- Undefined: wr_bank is tied to 0, o_ada[A_W-1]=0, and o_bank_tgl still toggles as a frame marker. The display may show tearing during writes.

Decomposition:
- Shared define file: CORROSION_DX, CORROSION_DY, CORRODE_MAP_CELLS (= DX*DY), and a state encoding localparam set (IDLE=0, CLEAR=1, RUN=2, DONE=3).
- No sub-module; the toggle-flag synchronizer lives in the display-side block.

Test Plan:
- Reset, then i_frame_start, then C_L*C_H valid cells with alternating wb. Expect writes to addresses 0..C_L*C_H-1 with the matching din, one o_frame_done, o_bank_tgl=1, and the next frame writing at base 1024.
- i_clr_req in IDLE. Expect o_cell_ready=0 for C_L*C_H cycles, all writes with din=1, then IDLE.
- i_clr_req and i_frame_start in the same cycle. Expect the full clear sweep first, then RUN with cell_cnt=0, and the first cell at address base+0.
- i_frame_start after 5 cells of a frame. Expect no o_frame_done, the next cell written at base+0, and wr_bank unchanged.
- Cell valid while IDLE. Expect no o_we, and o_overflow=1 staying high through the following frames.
- With CORRODE_PINGPONG_EN undefined, run two full frames. Expect both at base 0, and o_bank_tgl toggling twice.
